// File: rtl/alu_ctrl_decoder_pkg.sv
// alu_ctrl_pkg: shared ALU-control encodings and the decoded-control record
package alu_ctrl_pkg;

    // ALU operation select driven to the ALU
    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_OR    = 3'b011;
    localparam logic [2:0] OP_NOTA  = 3'b100;
    localparam logic [2:0] OP_PASSA = 3'b101;
    localparam logic [2:0] OP_PASSB = 3'b110;

    // Operation classes issued by the main FSM
    localparam logic [2:0] ALUOP_ADD  = 3'b000;
    localparam logic [2:0] ALUOP_SUB  = 3'b001;
    localparam logic [2:0] ALUOP_FUNC = 3'b010;
    localparam logic [2:0] ALUOP_AND  = 3'b011;
    localparam logic [2:0] ALUOP_OR   = 3'b100;

    // Bit positions inside the one-hot C-type function field
    localparam int F_MOVETO   = 0;
    localparam int F_MOVEFROM = 1;
    localparam int F_ADD      = 2;
    localparam int F_SUB      = 3;
    localparam int F_AND      = 4;
    localparam int F_OR       = 5;
    localparam int F_NOT      = 6;
    localparam int F_NOP      = 7;
    localparam int F_RSVD     = 8;

    // Decoded control bundle: ALU select plus the two write qualifiers
    typedef struct packed {
        logic [2:0] op;
        logic       notnoop;
        logic       alucowr;
    } ctrl_t;

endpackage

// File: rtl/alu_ctrl_decoder_if.sv
// alu_ctrl_decoder_if: control-class/function inputs and decoded ALU controls
interface alu_ctrl_decoder_if;
    import alu_ctrl_pkg::*;

    logic [2:0] ALUop;
    logic [8:0] func;
    logic [2:0] op;
    logic       notnoop;
    logic       ALUCoWr;
    logic       illegal_func;

    // master: the main controller issuing the class and function field
    modport master (output ALUop, func, input op, notnoop, ALUCoWr, illegal_func);
    // slave: the decoder itself
    modport slave (input ALUop, func, output op, notnoop, ALUCoWr, illegal_func);

endinterface

// File: rtl/alu_ctrl_decoder_func_decode.sv
// func_decode: priority decode of the C-type function field, lowest set bit wins
module func_decode
    import alu_ctrl_pkg::*;
(
    input  logic [8:0] func_i,
    output ctrl_t      res_o,
    output logic       onehot_ok_o
);

    logic [7:0] f;

    assign f = func_i[7:0];
    // Legal only when exactly one of the defined bits is set and the reserved bit is clear
    assign onehot_ok_o = (f != 8'd0) && ((f & (f - 8'd1)) == 8'd0) && !func_i[F_RSVD];

    // Lowest set bit picks the operation; Nop or an empty field suppresses the write
    always_comb begin
        res_o = '{op: OP_ADD, notnoop: 1'b1, alucowr: 1'b0};
        if (f[F_MOVETO])        res_o = '{op: OP_PASSA, notnoop: 1'b1, alucowr: 1'b1};
        else if (f[F_MOVEFROM]) res_o.op = OP_PASSB;
        else if (f[F_ADD])      res_o.op = OP_ADD;
        else if (f[F_SUB])      res_o.op = OP_SUB;
        else if (f[F_AND])      res_o.op = OP_AND;
        else if (f[F_OR])       res_o.op = OP_OR;
        else if (f[F_NOT])      res_o.op = OP_NOTA;
        else                    res_o.notnoop = 1'b0;
    end

endmodule

// File: rtl/alu_ctrl_decoder.sv
// alu_ctrl_decoder: ALU-control decode for the accumulator datapath with an illegal-function status flag
module alu_ctrl_decoder
    import alu_ctrl_pkg::*;
#(
    parameter bit STICKY_ERR = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    alu_ctrl_decoder_if.slave   bus
);

    ctrl_t fres;
    logic  onehot_ok;
    logic  is_func;
    logic  bad;
    logic  illegal_q;
    logic  illegal_d;

    func_decode u_func_decode (
        .func_i      (bus.func),
        .res_o       (fres),
        .onehot_ok_o (onehot_ok)
    );

    assign is_func = (bus.ALUop == ALUOP_FUNC);
    assign bad     = is_func && !onehot_ok;

    // Class decode; unused classes fall back to ADD so every input yields a defined output
    always_comb begin
        bus.op      = is_func                  ? fres.op :
                      bus.ALUop == ALUOP_SUB   ? OP_SUB  :
                      bus.ALUop == ALUOP_AND   ? OP_AND  :
                      bus.ALUop == ALUOP_OR    ? OP_OR   : OP_ADD;
        bus.notnoop = is_func ? fres.notnoop : 1'b1;
        bus.ALUCoWr = is_func && fres.alucowr;
        illegal_d   = STICKY_ERR ? (illegal_q | bad) : bad;
    end

    // Error flag: either accumulates until reset or mirrors the last cycle's check
    always_ff @(posedge clk or posedge rst) begin
        if (rst) illegal_q <= 1'b0;
        else     illegal_q <= illegal_d;
    end

    assign bus.illegal_func = illegal_q;

endmodule

// File: tb/tb_alu_ctrl_decoder.sv
// tb_alu_ctrl_decoder: table-driven scoreboard bench for sticky and non-sticky decoders
module tb_alu_ctrl_decoder;
    import alu_ctrl_pkg::*;

    typedef struct {
        logic [2:0] a;
        logic [8:0] f;
        logic [2:0] op;
        logic       nn;
        logic       cw;
        logic       bad;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    logic acc = 1'b0;
    logic prev_bad = 1'b0;
    vec_t vt[$];
    vec_t sb[$];

    always #5 clk = ~clk;

    alu_ctrl_decoder_if s_if ();
    alu_ctrl_decoder_if n_if ();

    alu_ctrl_decoder #(.STICKY_ERR(1'b1)) dut_s (.clk(clk), .rst(rst), .bus(s_if.slave));
    alu_ctrl_decoder #(.STICKY_ERR(1'b0)) dut_n (.clk(clk), .rst(rst), .bus(n_if.slave));

    task automatic chk(input string n, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h at %0t", n, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(logic [2:0] a, logic [8:0] f, logic [2:0] op, logic nn, logic cw, logic bad);
        vec_t v;
        v.a = a; v.f = f; v.op = op; v.nn = nn; v.cw = cw; v.bad = bad;
        return v;
    endfunction

    task automatic set_in(input logic [2:0] a, input logic [8:0] f);
        s_if.ALUop = a; s_if.func = f;
        n_if.ALUop = a; n_if.func = f;
    endtask

    // Drive one vector after a rising edge, score it on the following falling edge
    task automatic apply(input vec_t v);
        vec_t e;
        @(posedge clk);
        #1;
        set_in(v.a, v.f);
        sb.push_back(v);
        @(negedge clk);
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 8'd1, 8'd0);
            return;
        end
        e = sb.pop_front();
        chk($sformatf("op_s a=%0h f=%0h", e.a, e.f), {5'd0, s_if.op}, {5'd0, e.op});
        chk($sformatf("op_n a=%0h f=%0h", e.a, e.f), {5'd0, n_if.op}, {5'd0, e.op});
        chk($sformatf("notnoop a=%0h f=%0h", e.a, e.f), {7'd0, s_if.notnoop}, {7'd0, e.nn});
        chk($sformatf("alucowr a=%0h f=%0h", e.a, e.f), {7'd0, s_if.ALUCoWr}, {7'd0, e.cw});
        chk($sformatf("illegal_sticky a=%0h f=%0h", e.a, e.f), {7'd0, s_if.illegal_func}, {7'd0, acc});
        chk($sformatf("illegal_plain a=%0h f=%0h", e.a, e.f), {7'd0, n_if.illegal_func}, {7'd0, prev_bad});
        acc = acc | e.bad;
        prev_bad = e.bad;
    endtask

    initial begin
        set_in(3'b000, 9'h000);
        vt.push_back(mk(3'b000, 9'h000, OP_ADD,   1, 0, 0));
        vt.push_back(mk(3'b001, 9'h000, OP_SUB,   1, 0, 0));
        vt.push_back(mk(3'b011, 9'h000, OP_AND,   1, 0, 0));
        vt.push_back(mk(3'b100, 9'h000, OP_OR,    1, 0, 0));
        vt.push_back(mk(3'b111, 9'h000, OP_ADD,   1, 0, 0));
        vt.push_back(mk(3'b101, 9'h0FF, OP_ADD,   1, 0, 0));
        vt.push_back(mk(3'b110, 9'h100, OP_ADD,   1, 0, 0));
        vt.push_back(mk(3'b010, 9'h001, OP_PASSA, 1, 1, 0));
        vt.push_back(mk(3'b010, 9'h002, OP_PASSB, 1, 0, 0));
        vt.push_back(mk(3'b010, 9'h004, OP_ADD,   1, 0, 0));
        vt.push_back(mk(3'b010, 9'h008, OP_SUB,   1, 0, 0));
        vt.push_back(mk(3'b010, 9'h010, OP_AND,   1, 0, 0));
        vt.push_back(mk(3'b010, 9'h020, OP_OR,    1, 0, 0));
        vt.push_back(mk(3'b010, 9'h040, OP_NOTA,  1, 0, 0));
        vt.push_back(mk(3'b010, 9'h080, OP_ADD,   0, 0, 0));
        vt.push_back(mk(3'b000, 9'h080, OP_ADD,   1, 0, 0));
        vt.push_back(mk(3'b000, 9'h1FF, OP_ADD,   1, 0, 0));
        vt.push_back(mk(3'b010, 9'h000, OP_ADD,   0, 0, 1));
        vt.push_back(mk(3'b010, 9'h001, OP_PASSA, 1, 1, 0));
        vt.push_back(mk(3'b010, 9'h101, OP_PASSA, 1, 1, 1));
        vt.push_back(mk(3'b010, 9'h100, OP_ADD,   0, 0, 1));
        vt.push_back(mk(3'b010, 9'h0C0, OP_NOTA,  1, 0, 1));
        vt.push_back(mk(3'b010, 9'h002, OP_PASSB, 1, 0, 0));

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_sticky", {7'd0, s_if.illegal_func}, 8'd0);
        chk("reset_plain", {7'd0, n_if.illegal_func}, 8'd0);
        rst = 1'b0;

        foreach (vt[i]) apply(vt[i]);

        // Fresh reset, then one bad cycle with Add winning priority, then six legal cycles
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_reset_sticky", {7'd0, s_if.illegal_func}, 8'd0);
        acc = 1'b0;
        prev_bad = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        apply(mk(3'b010, 9'h0C4, OP_ADD, 1, 0, 1));
        repeat (6) apply(mk(3'b000, 9'h000, OP_ADD, 1, 0, 0));

        // Asynchronous reset pulse between edges clears the flag without touching the decode
        #2;
        chk("flag_set_before_async", {7'd0, s_if.illegal_func}, 8'd1);
        set_in(3'b010, 9'h008);
        rst = 1'b1;
        #1;
        chk("async_clear_sticky", {7'd0, s_if.illegal_func}, 8'd0);
        chk("async_op_unaffected", {5'd0, s_if.op}, {5'd0, OP_SUB});
        chk("async_nn_unaffected", {7'd0, s_if.notnoop}, 8'd1);
        rst = 1'b0;
        acc = 1'b0;
        prev_bad = 1'b0;
        apply(mk(3'b000, 9'h000, OP_ADD, 1, 0, 0));
        apply(mk(3'b000, 9'h000, OP_ADD, 1, 0, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout");
        $fatal(1);
    end

endmodule

// File: doc/alu_ctrl_decoder.md
Name: alu_ctrl_decoder

Overview:
- Combinational ALU-control decoder for the multi-cycle accumulator MIPS datapath.
- Maps the controller's 3-bit ALUop class, plus the 9-bit C-type function field, onto:
  - the 3-bit ALU operation select;
  - a "not NOP" write qualifier;
  - a destination-select qualifier, asserted for MoveTo.
- Sits inside the main control unit; its outputs feed the ALU and the register-write gating in the same cycle.
- Also holds a sticky, clocked illegal-function status flag for verification/debug.

Parameters:
- STICKY_ERR, default 1: 1 = illegal_func stays set until reset; 0 = illegal_func reflects only the previous cycle's check.

Ports:
- clk  input  1  system clock; used only by the illegal_func register.
- rst  input  1  asynchronous, active-high reset. Clears illegal_func.
- ALUop  input  3  operation class from the main FSM.
- func  input  9  one-hot C-type function field, instruction bits [8:0].
- op  output  3  ALU operation select (ALU_control).
- notnoop  output  1  1 unless the decoded C-type function is NOP.
- ALUCoWr  output  1  1 when the C-type result targets Ri rather than R0 (MoveTo).
- illegal_func  output  1  registered error flag.

Behaviour:
- Interface rule: one clock; reset is asynchronous and active-high (clk, rst).
- op encoding:
  - 000 ADD, 001 SUB, 010 AND, 011 OR, 100 NOT A (bitwise invert of A).
  - 101 PASS A (A = R0), 110 PASS B (B = Ri), 111 unused.
- ALUop decode (purely combinational, zero latency, independent of clk/rst):
  - 000 -> ADD (fetch PC+1, ADDI).
  - 001 -> SUB (BRANCHZ compare, SUBI).
  - 010 -> function decode, below.
  - 011 -> AND (ANDI).
  - 100 -> OR (ORI).
  - 101/110/111 -> ADD.
  - For every ALUop other than 010: notnoop=1, ALUCoWr=0.
- Function decode (ALUop=010), lowest set bit wins:
  - func[0] MoveTo: op=PASS A, ALUCoWr=1, notnoop=1.
  - func[1] MoveFrom: op=PASS B, ALUCoWr=0, notnoop=1.
  - func[2] Add -> ADD.
  - func[3] Sub -> SUB.
  - func[4] And -> AND.
  - func[5] Or -> OR.
  - func[6] Not -> NOT A.
  - func[7] Nop: op=ADD, notnoop=0, ALUCoWr=0.
  - For func[2] through func[6]: ALUCoWr=0, notnoop=1.
  - func[7:0]=0 (func[8] ignored) is treated as NOP: op=ADD, notnoop=0, ALUCoWr=0.
- No X propagation: every output is defined for all 2^12 input combinations.
- illegal_func:
  - Per-cycle condition `bad` = (ALUop==010) and (func[7:0] is not exactly one-hot, or func[8]=1).
  - On rst: illegal_func=0 immediately (asynchronous).
  - On posedge clk, STICKY_ERR=1: illegal_func <= illegal_func | bad.
  - On posedge clk, STICKY_ERR=0: illegal_func <= bad.
  - A reset asserted mid-operation clears the flag but does not affect the combinational outputs.
- Reset values: op, notnoop and ALUCoWr are combinational and have no reset value; illegal_func=0.

Decomposition:
- Shared package alu_ctrl_pkg holds:
  - ALU op constants (OP_ADD..OP_PASSB);
  - ALUop class constants (ALUOP_ADD=000, ALUOP_SUB=001, ALUOP_FUNC=010, ALUOP_AND=011, ALUOP_OR=100);
  - function bit indices (F_MOVETO=0 .. F_NOP=7, F_RSVD=8).
- One natural sub-module: func_decode, the priority one-hot decoder for func. It returns op, notnoop, ALUCoWr and an onehot_ok signal.

Test Plan:
- Directed ALUop classes: ALUop=000/001/011/100/111 with func=0 -> op=000/001/010/011/000, notnoop=1, ALUCoWr=0.
- C-type sweep: ALUop=010, func=9'h001 -> op=101, ALUCoWr=1, notnoop=1; func=9'h002 -> op=110, ALUCoWr=0.
- C-type sweep continued: func=9'h004/008/010/020/040 -> op=000/001/010/011/100, notnoop=1, ALUCoWr=0.
- NOP handling: ALUop=010 with func=9'h080, and with func=9'h000 -> notnoop=0, op=000, ALUCoWr=0. Same func=9'h080 with ALUop=000 -> notnoop=1.
- Priority and error flag: ALUop=010, func=9'h0C4 -> op=000 (Add wins), notnoop=1. After one clk edge illegal_func=1, and it stays 1 over 5 following legal cycles (STICKY_ERR=1).
- Async reset: with illegal_func=1, pulse rst between clock edges -> illegal_func=0 before the next edge. With STICKY_ERR=0, a single bad cycle followed by a legal cycle -> flag 1 for exactly one cycle.
